// File: rtl/axil_read_responder.sv
// AXI4-Lite read responder: queues AR beats, decodes one address window, reads a register bus.
// Optional WAIT timeout with forced SLVERR is enabled by defining AXIL_RD_TIMEOUT_EN.
module axil_read_responder #(
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int unsigned           WINDOW_SIZE    = 12,
    parameter int unsigned           AR_FIFO_DEPTH  = 4,
    parameter int unsigned           TIMEOUT_CYCLES = 256
) (
    input  logic                   s_axi_aclk,
    input  logic                   s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]  s_axi_araddr,
    input  logic [2:0]             s_axi_arprot,
    input  logic                   s_axi_arvalid,
    output logic                   s_axi_arready,
    output logic [DATA_WIDTH-1:0]  s_axi_rdata,
    output logic [1:0]             s_axi_rresp,
    output logic                   s_axi_rvalid,
    input  logic                   s_axi_rready,
    output logic                   reg_rd_req,
    output logic [WINDOW_SIZE-1:0] reg_rd_addr,
    input  logic                   reg_rd_ack,
    input  logic [DATA_WIDTH-1:0]  reg_rd_data,
    input  logic                   reg_rd_err,
    output logic                   rd_busy,
    output logic [15:0]            rd_timeout_cnt
);

    localparam int unsigned PtrW  = (AR_FIFO_DEPTH > 1) ? $clog2(AR_FIFO_DEPTH) : 1;
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned OffW  = WINDOW_SIZE - 2;
    localparam logic [1:0]  RespOkay   = 2'b00;
    localparam logic [1:0]  RespSlvErr = 2'b10;
    localparam logic [1:0]  RespDecErr = 2'b11;

    if (AR_FIFO_DEPTH < 2 || (AR_FIFO_DEPTH & (AR_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("AR_FIFO_DEPTH must be a power of 2 and >= 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    // Queue entry: {window hit, word offset}; the rest of the address is not needed downstream.
    logic [OffW:0]           fifo_q [AR_FIFO_DEPTH];
    logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]         count_q, count_d;
    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;
    logic                    req_q, req_d;
    logic [WINDOW_SIZE-1:0]  addr_q, addr_d;

    logic            full, empty, push, pop, ar_hit;
    logic [OffW:0]   head;

    logic unused_ar;
    assign unused_ar = ^{s_axi_arprot, s_axi_araddr[1:0]};

    assign full   = (count_q == CntW'(AR_FIFO_DEPTH));
    assign empty  = (count_q == '0);
    assign push   = s_axi_arvalid && !full;
    assign pop    = (state_q == StIdle) && !empty;
    assign ar_hit = (s_axi_araddr[ADDR_WIDTH-1:WINDOW_SIZE] ==
                     BASE_ADDR[ADDR_WIDTH-1:WINDOW_SIZE]);
    assign head   = fifo_q[rd_ptr_q];

`ifdef AXIL_RD_TIMEOUT_EN
    localparam int unsigned         WaitW  = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [DATA_WIDTH-1:0] ToData = DATA_WIDTH'(32'hDEAD_BEEF);
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic [15:0]      to_cnt_q, to_cnt_d;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CntW'(push) - CntW'(pop);
        state_d  = state_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        req_d    = 1'b0;
        addr_d   = addr_q;
`ifdef AXIL_RD_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
        to_cnt_d   = to_cnt_q;
`endif
        if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);

        case (state_q)
            StIdle: begin
                if (pop) begin
                    if (head[OffW]) begin
                        req_d   = 1'b1;
                        addr_d  = {head[OffW-1:0], 2'b00};
                        state_d = StWait;
`ifdef AXIL_RD_TIMEOUT_EN
                        wait_cnt_d = '0;
`endif
                    end else begin
                        rdata_d = '0;
                        rresp_d = RespDecErr;
                        state_d = StResp;
                    end
                end
            end
            StWait: begin
                if (reg_rd_ack) begin
                    rdata_d = reg_rd_data;
                    rresp_d = reg_rd_err ? RespSlvErr : RespOkay;
                    state_d = StResp;
`ifdef AXIL_RD_TIMEOUT_EN
                end else if (wait_cnt_q == WaitW'(TIMEOUT_CYCLES - 1)) begin
                    rdata_d = ToData;
                    rresp_d = RespSlvErr;
                    state_d = StResp;
                    if (to_cnt_q != 16'hFFFF) to_cnt_d = to_cnt_q + 16'd1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WaitW'(1);
`endif
                end
            end
            StResp: begin
                if (s_axi_rready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= StIdle;
            rdata_q  <= '0;
            rresp_q  <= '0;
            req_q    <= 1'b0;
            addr_q   <= '0;
`ifdef AXIL_RD_TIMEOUT_EN
            wait_cnt_q <= '0;
            to_cnt_q   <= '0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
`ifdef AXIL_RD_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
            to_cnt_q   <= to_cnt_d;
`endif
            if (push) fifo_q[wr_ptr_q] <= {ar_hit, s_axi_araddr[WINDOW_SIZE-1:2]};
        end
    end

    // Outputs read as zero for as long as reset is held, not just after the reset edge.
    assign s_axi_arready = s_axi_aresetn && !full;
    assign s_axi_rvalid  = s_axi_aresetn && (state_q == StResp);
    assign s_axi_rdata   = s_axi_aresetn ? rdata_q : '0;
    assign s_axi_rresp   = s_axi_aresetn ? rresp_q : '0;
    assign reg_rd_req    = s_axi_aresetn && req_q;
    assign reg_rd_addr   = s_axi_aresetn ? addr_q : '0;
    assign rd_busy       = s_axi_aresetn && ((state_q != StIdle) || !empty);
`ifdef AXIL_RD_TIMEOUT_EN
    assign rd_timeout_cnt = s_axi_aresetn ? to_cnt_q : '0;
`else
    assign rd_timeout_cnt = '0;
`endif

endmodule

// File: tb/tb_axil_read_responder.sv
// Self-checking bench for axil_read_responder; R beats are scored against a queue of
// expectations pushed at each AR handshake.
module tb_axil_read_responder;

    localparam int unsigned TO = 16;
`ifdef AXIL_RD_TIMEOUT_EN
    localparam bit TimeoutBuild = 1'b1;
`else
    localparam bit TimeoutBuild = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;
    logic        reg_rd_req;
    logic [11:0] reg_rd_addr;
    logic        reg_rd_ack;
    logic [31:0] reg_rd_data;
    logic        reg_rd_err;
    logic        rd_busy;
    logic [15:0] rd_timeout_cnt;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [33:0] sb[$];
    int          ack_mode = 0;  // 0: same cycle as req, 1: one cycle later, 2: never
    logic        force_ack = 1'b0;
    logic        req_d1 = 1'b0;

    always #5 clk = ~clk;

    axil_read_responder #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .BASE_ADDR     (32'h0),
        .WINDOW_SIZE   (12),
        .AR_FIFO_DEPTH (4),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rstn),
        .s_axi_araddr  (araddr),
        .s_axi_arprot  (arprot),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .reg_rd_req    (reg_rd_req),
        .reg_rd_addr   (reg_rd_addr),
        .reg_rd_ack    (reg_rd_ack),
        .reg_rd_data   (reg_rd_data),
        .reg_rd_err    (reg_rd_err),
        .rd_busy       (rd_busy),
        .rd_timeout_cnt(rd_timeout_cnt)
    );

    function automatic logic [31:0] model_data(input logic [11:0] off);
        case (off)
            12'h104: return 32'h1234_5678;
            12'h200: return 32'hA5A5_A5A5;
            default: return {20'hC0DE0, off};
        endcase
    endfunction

    function automatic logic [33:0] model_exp(input logic [31:0] addr);
        logic [11:0] off;
        if (addr[31:12] != 20'h0) return {2'b11, 32'h0};
        off = {addr[11:2], 2'b00};
        return {(off == 12'h200) ? 2'b10 : 2'b00, model_data(off)};
    endfunction

    // Register bus model
    always @(posedge clk) req_d1 <= reg_rd_req;
    assign reg_rd_ack  = force_ack || ((ack_mode == 0) ? reg_rd_req :
                                       (ack_mode == 1) ? req_d1 : 1'b0);
    assign reg_rd_data = model_data(reg_rd_addr);
    assign reg_rd_err  = (reg_rd_addr == 12'h200);

    // R channel scoreboard
    always @(negedge clk) begin
        if (rstn && rvalid && rready) begin
            logic [33:0] exp;
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL r_unexpected: got resp=%b data=%h, want no beat", rresp, rdata);
            end else begin
                exp = sb.pop_front();
                if ({rresp, rdata} !== exp) begin
                    n_bad++;
                    $display("FAIL r_beat: got resp=%b data=%h, want resp=%b data=%h",
                             rresp, rdata, exp[33:32], exp[31:0]);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the handshake edge.
    task automatic ar_send(input logic [31:0] addr, output bit ok);
        ok = 1'b0;
        araddr  = addr;
        arvalid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (arready) begin
                @(posedge clk); #1;
                if (ack_mode == 2 && TimeoutBuild) sb.push_back({2'b10, 32'hDEAD_BEEF});
                else sb.push_back(model_exp(addr));
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        arvalid = 1'b0;
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL ar_timeout: got arready=0 for 50 cycles, want handshake (addr %h)",
                     addr);
        end
    endtask

    task automatic drain();
        bit done = 1'b0;
        rready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (sb.size() == 0 && !rvalid) begin
                done = 1'b1;
                break;
            end
        end
        rready = 1'b0;
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL drain: got %0d beats outstanding, want 0", sb.size());
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({arready, rvalid, rdata, rresp, reg_rd_req, reg_rd_addr, rd_busy, rd_timeout_cnt}
            !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got arready=%b rvalid=%b rdata=%h rresp=%b req=%b busy=%b to=%h, want all 0",
                     arready, rvalid, rdata, rresp, reg_rd_req, rd_busy, rd_timeout_cnt);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (arready !== 1'b1 || rd_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: got arready=%b busy=%b, want 1 0", arready, rd_busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_hit();
        bit ok;
        ack_mode = 0;
        ar_send(32'h0000_0107, ok);
        @(negedge clk);
        n_cmp++;
        if (reg_rd_req !== 1'b0 || rvalid !== 1'b0 || rd_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL hit_c1: got req=%b rvalid=%b busy=%b, want 0 0 1",
                     reg_rd_req, rvalid, rd_busy);
        end
        @(negedge clk);
        n_cmp++;
        if (reg_rd_req !== 1'b1 || reg_rd_addr !== 12'h104 || rvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL hit_c2: got req=%b addr=%h rvalid=%b, want 1 104 0",
                     reg_rd_req, reg_rd_addr, rvalid);
        end
        @(negedge clk);
        n_cmp++;
        if (rvalid !== 1'b1 || rdata !== 32'h1234_5678 || rresp !== 2'b00 || reg_rd_req !== 1'b0)
        begin
            n_bad++;
            $display("FAIL hit_c3: got rvalid=%b data=%h resp=%b req=%b, want 1 12345678 00 0",
                     rvalid, rdata, rresp, reg_rd_req);
        end
        @(posedge clk); #1;
        drain();
    endtask

    task automatic test_miss();
        bit ok;
        bit req_seen = 1'b0;
        ar_send(32'h0000_1000, ok);
        @(negedge clk);
        req_seen |= reg_rd_req;
        n_cmp++;
        if (rvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL miss_c1: got rvalid=%b, want 0", rvalid);
        end
        @(negedge clk);
        req_seen |= reg_rd_req;
        n_cmp++;
        if (rvalid !== 1'b1 || rresp !== 2'b11 || rdata !== 32'h0 || req_seen) begin
            n_bad++;
            $display("FAIL miss_c2: got rvalid=%b resp=%b data=%h req_seen=%b, want 1 11 0 0",
                     rvalid, rresp, rdata, req_seen);
        end
        @(posedge clk); #1;
        drain();
    endtask

    task automatic test_err();
        bit ok;
        bit seen = 1'b0;
        ack_mode = 1;
        ar_send(32'h0000_0200, ok);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rvalid) begin
                seen = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!seen || rresp !== 2'b10 || rdata !== 32'hA5A5_A5A5) begin
            n_bad++;
            $display("FAIL err_resp: got rvalid=%b resp=%b data=%h, want 1 10 a5a5a5a5",
                     seen, rresp, rdata);
        end
        @(posedge clk); #1;
        drain();
        ack_mode = 0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [5] = '{32'h0, 32'h104, 32'h2000, 32'h8, 32'h200};
        int  accepted = 0;
        int  ready_hi = 0;
        bit  ok;
        rready = 1'b0;
        foreach (addrs[i]) begin
            ar_send(addrs[i], ok);
            if (ok) accepted++;
        end
        araddr  = 32'hC;
        arvalid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (arready) ready_hi++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (accepted != 5 || ready_hi != 0) begin
            n_bad++;
            $display("FAIL b2b_full: got accepted=%0d arready_hi=%0d, want 5 0",
                     accepted, ready_hi);
        end
        rready = 1'b1;
        ar_send(32'hC, ok);
        drain();
    endtask

    task automatic test_timeout();
        bit ok;
        int early = 0;
        ack_mode = 2;
        ar_send(32'h0000_0010, ok);
`ifdef AXIL_RD_TIMEOUT_EN
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            if (rvalid) early++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_cmp++;
        if (early != 0 || rvalid !== 1'b1 || rdata !== 32'hDEAD_BEEF || rresp !== 2'b10 ||
            rd_timeout_cnt !== 16'd1) begin
            n_bad++;
            $display("FAIL timeout_resp: got early=%0d rvalid=%b data=%h resp=%b cnt=%0d, want 0 1 deadbeef 10 1",
                     early, rvalid, rdata, rresp, rd_timeout_cnt);
        end
        @(posedge clk); #1;
        force_ack = 1'b1;
        @(posedge clk); #1;
        force_ack = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rvalid !== 1'b1 || rdata !== 32'hDEAD_BEEF || rd_timeout_cnt !== 16'd1) begin
            n_bad++;
            $display("FAIL timeout_late_ack: got rvalid=%b data=%h cnt=%0d, want 1 deadbeef 1",
                     rvalid, rdata, rd_timeout_cnt);
        end
        @(posedge clk); #1;
`else
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (rvalid) early++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (early != 0 || rd_timeout_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL no_timeout: got rvalid_cycles=%0d cnt=%0d, want 0 0",
                     early, rd_timeout_cnt);
        end
        force_ack = 1'b1;
        @(posedge clk); #1;
        force_ack = 1'b0;
`endif
        drain();
        ack_mode = 0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen = 1'b0;
        int stray = 0;
        rready = 1'b0;
        ar_send(32'h0000_0104, ok);
        ar_send(32'h0000_0008, ok);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (rvalid) begin
                seen = 1'b1;
                break;
            end
        end
        rstn = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (!seen || rvalid !== 1'b0 || arready !== 1'b0 || rd_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_in: got seen=%b rvalid=%b arready=%b busy=%b, want 1 0 0 0",
                     seen, rvalid, arready, rd_busy);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        sb.delete();
        @(negedge clk);
        n_cmp++;
        if (arready !== 1'b1 || rvalid !== 1'b0 || rd_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_out: got arready=%b rvalid=%b busy=%b, want 1 0 0",
                     arready, rvalid, rd_busy);
        end
        rready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (rvalid) stray++;
        end
        rready = 1'b0;
        n_cmp++;
        if (stray != 0) begin
            n_bad++;
            $display("FAIL mid_reset_stale: got %0d rvalid cycles, want 0", stray);
        end
        ar_send(32'h0000_0104, ok);
        drain();
    endtask

    initial begin
        test_reset();
        test_hit();
        test_miss();
        test_err();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500us, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
